// File: rtl/mac_pkg.sv
// Shared encodings for the k-furthest-neighbours MAC tile.
// Op selects, instruction bit positions and the OS dataflow states.
package mac_pkg;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_L1  = 2'b01;
    localparam logic [1:0] OP_L2  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int INST_OS   = 2;
    localparam int INST_EXEC = 1;
    localparam int INST_LS   = 0;

    typedef enum logic {
        ACC   = 1'b0,
        DRAIN = 1'b1
    } os_state_t;

endpackage

// File: rtl/mac_op_unit.sv
// Combinational distance term f(a,b,op) and the (optionally saturating) add.
// Shared by the WS and OS datapaths of the tile.
module mac_op_unit
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter bit SAT     = 1'b1
) (
    input  logic [bw-1:0]      a,
    input  logic [bw-1:0]      b,
    input  logic [1:0]         op,
    input  logic [psum_bw-1:0] base,
    output logic [psum_bw-1:0] sum,
    output logic               ovf
);

    localparam int TW = 2 * bw + 2;

    localparam logic [psum_bw-1:0] PMAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] PMIN = {1'b1, {(psum_bw-1){1'b0}}};

    logic [TW-1:0]    a_x;
    logic [TW-1:0]    b_x;
    logic [TW-1:0]    diff;
    logic [TW-1:0]    term;
    logic [psum_bw:0] r;

    // Term selection, one guard bit on the add, clamp when saturating
    always_comb begin
        a_x  = {{(bw+2){a[bw-1]}}, a};
        b_x  = {{(bw+2){b[bw-1]}}, b};
        diff = a_x - b_x;
        term = '0;
        unique case (op)
            OP_MUL:  term = a_x * b_x;
            OP_L1:   term = diff[TW-1] ? (~diff + 1'b1) : diff;
            OP_L2:   term = diff * diff;
            default: term = '0;
        endcase
        r   = {base[psum_bw-1], base}
            + {{(psum_bw+1-TW){term[TW-1]}}, term};
        sum = r[psum_bw-1:0];
        ovf = 1'b0;
        if (SAT && (r[psum_bw] != r[psum_bw-1])) begin
            ovf = 1'b1;
            sum = r[psum_bw] ? PMIN : PMAX;
        end
    end

endmodule

// File: rtl/mac_tile_knn.sv
// Reconfigurable WS/OS processing element for the k-furthest-neighbours array.
// Activations/instructions flow west->east, partial sums north->south.
module mac_tile_knn
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter bit SAT     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      in_w,
    input  logic [psum_bw-1:0] in_n,
    input  logic [2:0]         inst_w,
    input  logic [1:0]         op_w,
    output logic [bw-1:0]      out_e,
    output logic [2:0]         inst_e,
    output logic [1:0]         op_e,
    output logic [psum_bw-1:0] out_s,
    output logic               ovf
);

    logic [psum_bw-1:0] acc;
    logic [bw-1:0]      w_q;
    logic               w_loaded;
    os_state_t          state;

    logic               os;
    logic               exec;
    logic               ls;
    logic [bw-1:0]      opnd_b;
    logic [psum_bw-1:0] base;
    logic [psum_bw-1:0] sum;
    logic               add_ovf;
    logic [psum_bw-1:0] b_sext;

    assign os     = inst_w[INST_OS];
    assign exec   = inst_w[INST_EXEC];
    assign ls     = inst_w[INST_LS];
    assign b_sext = {{(psum_bw-bw){in_n[bw-1]}}, in_n[bw-1:0]};

    // OS accumulates onto acc (restarting from 0 after a drain); WS onto in_n
    assign opnd_b = os ? in_n[bw-1:0] : w_q;
    assign base   = os ? ((state == DRAIN) ? '0 : acc) : in_n;

    mac_op_unit #(
        .bw      (bw),
        .psum_bw (psum_bw),
        .SAT     (SAT)
    ) u_op (
        .a    (in_w),
        .b    (opnd_b),
        .op   (op_w),
        .base (base),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    // Eastward forwarding plus the WS/OS datapath and ACC/DRAIN state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            out_e    <= '0;
            inst_e   <= '0;
            op_e     <= '0;
            out_s    <= '0;
            ovf      <= 1'b0;
            acc      <= '0;
            w_q      <= '0;
            w_loaded <= 1'b0;
            state    <= ACC;
        end else begin
            out_e  <= in_w;
            inst_e <= inst_w;
            op_e   <= op_w;
            if (os) begin
                unique case (1'b1)
                    (exec && !ls): begin
                        acc   <= sum;
                        ovf   <= ovf | add_ovf;
                        out_s <= b_sext;
                        state <= ACC;
                    end
                    (!exec && ls): begin
                        out_s <= acc;
                        acc   <= '0;
                        state <= DRAIN;
                    end
                    (exec && ls && state == DRAIN): begin
                        out_s <= in_n;
                    end
                    default: begin
                        state <= ACC;
                    end
                endcase
            end else begin
                unique case (1'b1)
                    (ls && !w_loaded): begin
                        w_q      <= in_n[bw-1:0];
                        w_loaded <= 1'b1;
                        out_s    <= '0;
                    end
                    (ls && w_loaded): begin
                        out_s <= in_n;
                    end
                    (exec && !ls): begin
                        out_s <= sum;
                        ovf   <= ovf | add_ovf;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
